// File: rtl/pc_unit_pkg.sv
// ============================================================================
// Module      : pc_unit_pkg
// Description : Shared state encodings, default sizes and helpers for pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

    localparam int unsigned BITS_FOR_STATE_COUNTER_PC_UNIT = 2;

    localparam int unsigned DEFAULT_PC_SIZE     = 32;
    localparam int unsigned DEFAULT_INSTR_BYTES = 4;
    localparam int unsigned DEFAULT_COUNT_SIZE  = 32;

    typedef enum logic [BITS_FOR_STATE_COUNTER_PC_UNIT-1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_STEP_WAIT = 2'b10,
        ST_HALTED    = 2'b11
    } pc_state_e;

    // Clears the n least-significant bits of a value (up to 64 bits wide).
    function automatic logic [63:0] clear_lsbs(input logic [63:0] value,
                                               input int unsigned n);
        logic [63:0] mask;
        mask = ~64'd0 << n;
        return value & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_unit_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that saturates at all-ones and never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
    import pc_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_COUNT_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (enable && inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : IF-stage program counter with redirect, single-step, freeze
//               and a saturating advance counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned         PC_SIZE      = DEFAULT_PC_SIZE,
    parameter logic [PC_SIZE-1:0]  RESET_VECTOR = '0,
    parameter int unsigned         INSTR_BYTES  = DEFAULT_INSTR_BYTES,
    parameter int unsigned         COUNT_SIZE   = DEFAULT_COUNT_SIZE
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_start,
    input  logic                  i_halt,
    input  logic                  i_stall,
    input  logic                  i_redirect,
    input  logic [PC_SIZE-1:0]    i_redirect_pc,
    input  logic                  i_step_mode,
    input  logic                  i_step,
    output logic [PC_SIZE-1:0]    o_pc,
    output logic [PC_SIZE-1:0]    o_seq_pc,
    output logic [1:0]            o_state,
    output logic                  o_running,
    output logic                  o_halted,
    output logic [COUNT_SIZE-1:0] o_advance_count
);

    localparam int unsigned        C_ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [PC_SIZE-1:0] C_INCREMENT  = PC_SIZE'(INSTR_BYTES);

    pc_state_e          state_q;
    pc_state_e          state_d;
    logic [PC_SIZE-1:0] pc_q;
    logic [PC_SIZE-1:0] pc_d;
    logic [PC_SIZE-1:0] w_seq_pc;
    logic [PC_SIZE-1:0] w_redirect_target;
    logic               w_pc_load;

    assign w_seq_pc          = pc_q + C_INCREMENT;
    assign w_redirect_target = PC_SIZE'(clear_lsbs(64'(i_redirect_pc), C_ALIGN_BITS));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // w_pc_load marks the cycles that move the PC; it also feeds the counter.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        w_pc_load = 1'b0;
        if (i_enable) begin
            case (state_q)
                ST_IDLE: begin
                    pc_d = RESET_VECTOR;
                    if (i_start) begin
                        state_d = i_step_mode ? ST_STEP_WAIT : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        if (i_redirect) begin
                            pc_d      = w_redirect_target;
                            w_pc_load = 1'b1;
                        end else if (!i_stall) begin
                            pc_d      = w_seq_pc;
                            w_pc_load = 1'b1;
                        end
                        if (i_step_mode) begin
                            state_d = ST_STEP_WAIT;
                        end
                    end
                end
                ST_STEP_WAIT: begin
                    if (i_halt) begin
                        state_d = ST_HALTED;
                    end else if (!i_step_mode) begin
                        state_d = ST_RUN;
                    end else if (i_step && i_redirect) begin
                        pc_d      = w_redirect_target;
                        w_pc_load = 1'b1;
                    end else if (i_step && !i_stall) begin
                        pc_d      = w_seq_pc;
                        w_pc_load = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HALTED;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (COUNT_SIZE)
    ) u_advance_counter (
        .clk    (i_clk),
        .reset  (i_reset),
        .enable (i_enable),
        .inc    (w_pc_load),
        .count  (o_advance_count)
    );

    assign o_pc      = pc_q;
    assign o_seq_pc  = w_seq_pc;
    assign o_state   = state_q;
    assign o_running = (state_q == ST_RUN) || (state_q == ST_STEP_WAIT);
    assign o_halted  = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit (32-bit and 8-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    localparam logic [31:0] RV32 = 32'h100;
    localparam logic [7:0]  RV8  = 8'hF0;

    logic        clk = 1'b0;
    logic        rst, en, start, halt, stall, redir, smode, step;
    logic [31:0] rpc;

    logic [31:0] pc32, seq32;
    logic [1:0]  st32;
    logic        run32, hlt32;
    logic [31:0] cnt32;

    logic [7:0]  pc8, seq8;
    logic [1:0]  st8;
    logic        run8, hlt8;
    logic [3:0]  cnt8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_SIZE      (32),
        .RESET_VECTOR (RV32),
        .INSTR_BYTES  (4),
        .COUNT_SIZE   (32)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_enable        (en),
        .i_start         (start),
        .i_halt          (halt),
        .i_stall         (stall),
        .i_redirect      (redir),
        .i_redirect_pc   (rpc),
        .i_step_mode     (smode),
        .i_step          (step),
        .o_pc            (pc32),
        .o_seq_pc        (seq32),
        .o_state         (st32),
        .o_running       (run32),
        .o_halted        (hlt32),
        .o_advance_count (cnt32)
    );

    pc_unit #(
        .PC_SIZE      (8),
        .RESET_VECTOR (RV8),
        .INSTR_BYTES  (4),
        .COUNT_SIZE   (4)
    ) dut8 (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_enable        (en),
        .i_start         (start),
        .i_halt          (halt),
        .i_stall         (stall),
        .i_redirect      (redir),
        .i_redirect_pc   (rpc[7:0]),
        .i_step_mode     (smode),
        .i_step          (step),
        .o_pc            (pc8),
        .o_seq_pc        (seq8),
        .o_state         (st8),
        .o_running       (run8),
        .o_halted        (hlt8),
        .o_advance_count (cnt8)
    );

    // Reference model: mode codes follow the published state encoding.
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;
    int              m_mode;
    longint unsigned m_pc32, m_pc8, m_adv;

    task automatic model_step();
        int action; // 0 hold, 1 sequential, 2 redirect
        action = 0;
        if (rst) begin
            m_mode = M_IDLE; m_pc32 = RV32; m_pc8 = RV8; m_adv = 0;
        end else if (en) begin
            if (m_mode == M_IDLE) begin
                m_pc32 = RV32; m_pc8 = RV8;
                if (start) m_mode = smode ? M_WAIT : M_RUN;
            end else if (m_mode == M_RUN) begin
                if (halt) m_mode = M_HALT;
                else begin
                    action = redir ? 2 : (stall ? 0 : 1);
                    if (smode) m_mode = M_WAIT;
                end
            end else if (m_mode == M_WAIT) begin
                if (halt) m_mode = M_HALT;
                else if (!smode) m_mode = M_RUN;
                else if (step) action = redir ? 2 : (stall ? 0 : 1);
            end
            if (action == 1) begin
                m_pc32 = (m_pc32 + 4) % 64'h1_0000_0000;
                m_pc8  = (m_pc8 + 4) % 256;
            end else if (action == 2) begin
                m_pc32 = longint'(rpc) & 64'hFFFF_FFFC;
                m_pc8  = longint'(rpc) & 64'hFC;
            end
            if (action != 0) m_adv = m_adv + 1;
        end
    endtask

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("pc32", pc32, m_pc32);
        chk("seq32", seq32, (m_pc32 + 4) % 64'h1_0000_0000);
        chk("state32", st32, m_mode);
        chk("running32", run32, (m_mode == M_RUN || m_mode == M_WAIT));
        chk("halted32", hlt32, (m_mode == M_HALT));
        chk("count32", cnt32, m_adv);
        chk("pc8", pc8, m_pc8);
        chk("seq8", seq8, (m_pc8 + 4) % 256);
        chk("state8", st8, m_mode);
        chk("count8", cnt8, (m_adv > 15) ? 15 : m_adv);
    endtask

    task automatic cycle(input logic i_rst, input logic i_en, input logic i_st,
                         input logic i_hl, input logic i_sl, input logic i_rd,
                         input logic [31:0] i_rpc, input logic i_sm, input logic i_sp);
        rst = i_rst; en = i_en; start = i_st; halt = i_hl; stall = i_sl;
        redir = i_rd; rpc = i_rpc; smode = i_sm; step = i_sp;
        @(posedge clk);
        #1;
        model_step();
        check_model();
    endtask

    typedef struct {
        logic        rst, en, start, halt, stall, redir;
        logic [31:0] rpc;
        logic        smode, step;
        logic [31:0] e_pc;
        logic [1:0]  e_state;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic s,
                                input logic h, input logic sl, input logic rd,
                                input logic [31:0] rp, input logic sm,
                                input logic sp, input logic [31:0] pc,
                                input logic [1:0] st, input logic [31:0] c);
        vec_t v;
        v.rst = r; v.en = e; v.start = s; v.halt = h; v.stall = sl; v.redir = rd;
        v.rpc = rp; v.smode = sm; v.step = sp; v.e_pc = pc; v.e_state = st; v.e_cnt = c;
        return v;
    endfunction

    initial begin
        m_mode = M_IDLE; m_pc32 = RV32; m_pc8 = RV8; m_adv = 0;
        rst = 1; en = 1; start = 0; halt = 0; stall = 0; redir = 0;
        rpc = 0; smode = 0; step = 0;

        //            rst en st hl sl rd rpc         sm sp  pc          st    cnt
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h100,  2'd0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,    0, 0, 32'h100,  2'd1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h104,  2'd1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h108,  2'd1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h10C,  2'd1, 3));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'h2003, 0, 0, 32'h2000, 2'd1, 4));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,    0, 0, 32'h2000, 2'd1, 4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h40,   0, 0, 32'h40,   2'd1, 5));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 32'h80,   0, 0, 32'h40,   2'd3, 5));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h300,  0, 0, 32'h40,   2'd3, 5));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h100,  2'd0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,    1, 0, 32'h100,  2'd2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    1, 0, 32'h100,  2'd2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    1, 1, 32'h104,  2'd2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,    1, 1, 32'h104,  2'd2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    1, 1, 32'h108,  2'd2, 2));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(0, 0, i[0], 0, 0, ~i[0], 32'h500, 1, 1, 32'h108, 2'd2, 2));
        end
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h108,  2'd1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    0, 0, 32'h10C,  2'd1, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,    1, 0, 32'h110,  2'd2, 4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h1237, 1, 1, 32'h1234, 2'd2, 5));

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].en, tbl[i].start, tbl[i].halt, tbl[i].stall,
                  tbl[i].redir, tbl[i].rpc, tbl[i].smode, tbl[i].step);
            chk($sformatf("vec%0d_pc", i), pc32, tbl[i].e_pc);
            chk($sformatf("vec%0d_state", i), st32, tbl[i].e_state);
            chk($sformatf("vec%0d_count", i), cnt32, tbl[i].e_cnt);
        end

        // 8-bit wrap from 0xFC to 0x00 and 4-bit counter saturation.
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc8", pc8, 0);
        chk("wrap_pc32", pc32, 32'h110);
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_count8", cnt8, 4'hF);
        chk("count32_20", cnt32, 20);

        // Randomised traffic against the model.
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
